floor_call_panel: RTL and testbench



---
 rtl/elev_pkg.sv | 15 +
 rtl/btn_debounce.sv | 63 ++++++
 rtl/floor_call_panel.sv | 145 ++++++++++++++
 tb/tb_floor_call_panel.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared elevator types: floor index type, default sizing and the call-panel FSM states.
package elev_pkg;

    localparam int unsigned NUM_FLOORS_DEF = 8;
    localparam int unsigned FLOOR_W_DEF    = 3;

    typedef logic [FLOOR_W_DEF-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } panel_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One call button: two-flop synchroniser plus optional stability filter.
// The filter is built only when BTN_DEBOUNCE_EN is defined; otherwise filt is the synchronised bit.
module btn_debounce
`ifdef BTN_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    logic meta;
    logic sync;

    // Two-stage synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             sync_q;
    logic             filt_r;

    // Any change restarts the count; the new level is accepted after a full stable run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sync_q <= 1'b0;
            filt_r <= 1'b0;
        end else begin
            sync_q <= sync;
            if (sync != sync_q) begin
                cnt <= '0;
            end else begin
                if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_r <= sync;
                end
            end
        end
    end

    assign filt = filt_r;
`else
    assign filt = sync;
`endif

endmodule

// File: rtl/floor_call_panel.sv
// Floor call panel: latches per-floor button presses and issues each pending call once,
// round-robin, as a single-cycle press_dest strobe. Debounce enabled by BTN_DEBOUNCE_EN.
module floor_call_panel
    import elev_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = NUM_FLOORS_DEF,
    parameter int unsigned FLOOR_W         = FLOOR_W_DEF,
`ifdef BTN_DEBOUNCE_EN
    parameter int unsigned DEBOUNCE_CYCLES = 16,
`endif
    parameter int unsigned ISSUE_GAP       = 2
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn_raw,
    input  logic                  stop,
    input  logic [FLOOR_W-1:0]    last_floor_stop,
    output logic [FLOOR_W-1:0]    dest_floor,
    output logic                  press_dest,
    output logic [NUM_FLOORS-1:0] call_lamp,
    output logic                  req_pending
);

    localparam int unsigned IDX_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int unsigned GAP_W = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;

    logic [NUM_FLOORS-1:0] filt;
    logic [NUM_FLOORS-1:0] filt_q;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] issued;
    logic [NUM_FLOORS-1:0] pend_nxt;
    logic [NUM_FLOORS-1:0] iss_nxt;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [NUM_FLOORS-1:0] iss_mask;
    logic [NUM_FLOORS-1:0] elig;
    logic [FLOOR_W-1:0]    rr_ptr;
    logic [FLOOR_W-1:0]    sel_idx;
    logic                  sel_valid;
    logic [GAP_W-1:0]      gap_cnt;
    int unsigned           cand;
    panel_state_t          state;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
        btn_debounce
`ifdef BTN_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
            u_btn (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (btn_raw[f]),
                .filt  (filt[f])
            );
    end

    assign press     = filt & ~filt_q;
    assign call_lamp = pending;

    // Service clears win over a same-cycle press or issue; repeated presses are idempotent.
    always_comb begin
        clr_mask = '0;
        iss_mask = '0;
        if (stop) begin
            clr_mask = NUM_FLOORS'(1) << last_floor_stop;
        end
        if (state == ISSUE) begin
            iss_mask = NUM_FLOORS'(1) << dest_floor;
        end
        pend_nxt = (pending | press) & ~clr_mask;
        iss_nxt  = (issued | iss_mask) & ~clr_mask;
    end

    // Round-robin pick: search rr_ptr+1 upwards with wrap, rr_ptr itself last.
    always_comb begin
        elig      = pending & ~issued;
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned i = NUM_FLOORS; i > 0; i--) begin
            cand = (32'(rr_ptr) + i) % NUM_FLOORS;
            if (elig[IDX_W'(cand)]) begin
                sel_valid = 1'b1;
                sel_idx   = FLOOR_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q      <= '0;
            pending     <= '0;
            issued      <= '0;
            req_pending <= 1'b0;
        end else begin
            filt_q      <= filt;
            pending     <= pend_nxt;
            issued      <= iss_nxt;
            req_pending <= |pend_nxt;
        end
    end

    // Issue FSM: select in IDLE, strobe for one cycle in ISSUE, then hold off through GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dest_floor <= '0;
            press_dest <= 1'b0;
            rr_ptr     <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        dest_floor <= sel_idx;
                        press_dest <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    press_dest <= 1'b0;
                    rr_ptr     <= dest_floor;
                    if (ISSUE_GAP > 1) begin
                        gap_cnt <= GAP_W'(ISSUE_GAP - 1);
                        state   <= GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    press_dest <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floor_call_panel.sv
// Bench for floor_call_panel: directed scenarios plus random traffic against a cycle-level
// reference built from the call rules (bitsets, issue spacing, round-robin search).
module tb_floor_call_panel;

    localparam int ISSUE_GAP = 2;
`ifdef BTN_DEBOUNCE_EN
    localparam int DEB = 16;
    localparam int PL  = 20;
    localparam int WT  = 40;
`else
    localparam int PL  = 3;
    localparam int WT  = 20;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_raw = 8'h00;
    logic       stop = 1'b0;
    logic [2:0] last_floor_stop = 3'd0;
    logic [2:0] dest_floor;
    logic       press_dest;
    logic [7:0] call_lamp;
    logic       req_pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference state
    logic [7:0] m_s1, m_s2, m_fq, m_pend, m_iss;
    logic [2:0] m_rr, m_dest;
    logic       m_strobe;
    int         m_last;
`ifdef BTN_DEBOUNCE_EN
    int         m_cnt [8];
    logic [7:0] m_sq, m_filt;
`endif

    logic [2:0] log_q[$];
    logic [2:0] exp_q[$];

    floor_call_panel dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .btn_raw         (btn_raw),
        .stop            (stop),
        .last_floor_stop (last_floor_stop),
        .dest_floor      (dest_floor),
        .press_dest      (press_dest),
        .call_lamp       (call_lamp),
        .req_pending     (req_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_fq = 0; m_pend = 0; m_iss = 0;
        m_rr = 0; m_dest = 0; m_strobe = 0; m_last = -100;
`ifdef BTN_DEBOUNCE_EN
        for (int f = 0; f < 8; f++) m_cnt[f] = 0;
        m_sq = 0; m_filt = 0;
`endif
    endtask

    // One clock: advance the reference with the inputs held across the edge, then compare.
    task automatic step();
        logic [7:0] filt_pre, press, clr, elig;
        logic       sel_ok;
        logic [2:0] pick;
        int         c;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
`ifdef BTN_DEBOUNCE_EN
            filt_pre = m_filt;
`else
            filt_pre = m_s2;
`endif
            press = filt_pre & ~m_fq;
            clr   = stop ? (8'(1) << last_floor_stop) : 8'h00;
            elig  = m_pend & ~m_iss;
            pick  = 3'd0;
            sel_ok = 1'b0;
            if (!m_strobe && (cyc - m_last >= ISSUE_GAP) && elig != 8'h00) begin
                sel_ok = 1'b1;
                for (int i = 8; i >= 1; i--) begin
                    c = (int'(m_rr) + i) % 8;
                    if (elig[c]) pick = 3'(c);
                end
            end
`ifdef BTN_DEBOUNCE_EN
            for (int f = 0; f < 8; f++) begin
                if (m_s2[f] != m_sq[f]) m_cnt[f] = 0;
                else begin
                    if (m_cnt[f] == DEB - 1) m_filt[f] = m_s2[f];
                    if (m_cnt[f] != DEB) m_cnt[f]++;
                end
            end
            m_sq = m_s2;
`endif
            m_fq = filt_pre;
            m_s2 = m_s1;
            m_s1 = btn_raw;
            if (m_strobe) begin
                m_iss = m_iss | (8'(1) << m_dest);
                m_rr  = m_dest;
            end
            m_pend = (m_pend | press) & ~clr;
            m_iss  = m_iss & ~clr;
            m_strobe = sel_ok;
            if (sel_ok) begin
                m_dest = pick;
                m_last = cyc + 1;
            end
        end
        cyc++;
        chk("press_dest", 32'(press_dest), 32'(m_strobe));
        chk("call_lamp", 32'(call_lamp), 32'(m_pend));
        chk("req_pending", 32'(req_pending), 32'(|m_pend));
        if (m_strobe) chk("dest_floor", 32'(dest_floor), 32'(m_dest));
        if (press_dest) log_q.push_back(dest_floor);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic [7:0] mask, input int len);
        btn_raw = btn_raw | mask;
        steps(len);
        btn_raw = btn_raw & ~mask;
    endtask

    task automatic service(input int f);
        stop = 1'b1;
        last_floor_stop = 3'(f);
        step();
        stop = 1'b0;
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) chk({tag, "_order"}, 32'(log_q[i]), 32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        model_reset();

        // reset held with every button pressed
        btn_raw = 8'hFF;
        rst_n = 1'b0;
        steps(4);
        chk("reset_lamp", 32'(call_lamp), 32'h0);
        chk("reset_strobe", 32'(press_dest), 32'h0);
        log_q.delete();
        rst_n = 1'b1;
        steps(3 * WT);
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        check_log("reset_rr");
        btn_raw = 8'h00;
        for (int f = 0; f < 8; f++) service(f);
        steps(4);

        // single press on floor 5
        pulse(8'h20, PL);
        steps(2);
        chk("single_lamp", 32'(call_lamp), 32'h20);
        steps(WT);
        exp_q = '{3'd5};
        check_log("single");

        // service floor 5 while it is pressed again
        stop = 1'b1;
        last_floor_stop = 3'd5;
        btn_raw[5] = 1'b1;
        steps(PL + 6);
        btn_raw[5] = 1'b0;
        steps(4);
        stop = 1'b0;
        chk("service_lamp", 32'(call_lamp), 32'h0);
        steps(WT);
        check_log("service");

        // round-robin from floor 3 over {1,4,6}
        pulse(8'h08, PL);
        steps(WT);
        exp_q = '{3'd3};
        check_log("rr_setup");
        service(3);
        pulse(8'h52, PL);
        steps(WT);
        exp_q = '{3'd4, 3'd6, 3'd1};
        check_log("rr_order");
        service(1); service(4); service(6);

        // duplicate press before service
        pulse(8'h04, PL);
        steps(3);
        pulse(8'h04, PL);
        steps(WT);
        exp_q = '{3'd2};
        check_log("duplicate");
        service(2);
        steps(4);

`ifdef BTN_DEBOUNCE_EN
        pulse(8'h08, 10);
        steps(WT);
        check_log("glitch");
        pulse(8'h08, 20);
        steps(WT);
        exp_q = '{3'd3};
        check_log("deb_press");
        service(3);
        btn_raw[3] = 1'b1;
        steps(8);
        rst_n = 1'b0;
        btn_raw[3] = 1'b0;
        step();
        rst_n = 1'b1;
        steps(WT);
        check_log("deb_reset");
`endif

        // random traffic with occasional service stops and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) btn_raw[$urandom_range(0, 7)] ^= 1'b1;
            stop = ($urandom_range(0, 3) == 0);
            last_floor_stop = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        log_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
